// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller: op encodings,
// default cycle counts, FSM state type and op-class helpers.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational 64-bit multiply / 32-bit divide. Divide-by-zero yields LO=all ones, HI=dividend;
// the controller decides whether that result is committed.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  always_comb begin
    w_prod  = '0;
    w_mag_a = '0;
    w_mag_b = '0;
    w_quo   = '0;
    w_rem   = '0;
    o_hi    = '0;
    o_lo    = '0;
    case (i_op)
      MD_MULT: begin
        // Low 64 bits of a product of sign-extended operands equal the signed product.
        w_prod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        o_hi   = w_prod[63:32];
        o_lo   = w_prod[31:0];
      end
      MD_MULTU: begin
        w_prod = {32'd0, i_a} * {32'd0, i_b};
        o_hi   = w_prod[63:32];
        o_lo   = w_prod[31:0];
      end
      MD_DIV: begin
        if (i_b == 32'd0) begin
          o_hi = i_a;
          o_lo = 32'hFFFF_FFFF;
        end else begin
          // Magnitude divide; 0x80000000 negates to itself, which covers the overflow case.
          w_mag_a = i_a[31] ? -i_a : i_a;
          w_mag_b = i_b[31] ? -i_b : i_b;
          w_quo   = w_mag_a / w_mag_b;
          w_rem   = w_mag_a % w_mag_b;
          o_lo    = (i_a[31] ^ i_b[31]) ? -w_quo : w_quo;
          o_hi    = i_a[31] ? -w_rem : w_rem;
        end
      end
      MD_DIVU: begin
        if (i_b == 32'd0) begin
          o_hi = i_a;
          o_lo = 32'hFFFF_FFFF;
        end else begin
          o_lo = i_a / i_b;
          o_hi = i_a % i_b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: busy counter, HI/LO registers, MT/MF access and D-stage stall.
// Define MDU_DIVZERO_HOLD_EN to leave HI/LO untouched when a divide by zero commits.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_mdout
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e        r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [31:0]      r_hi, r_lo, r_temp_hi, r_temp_lo;
  logic             r_skip;
  logic             w_launch, w_commit, w_skip;
  logic [31:0]      w_calc_hi, w_calc_lo;

  mdu_calc u_calc (
    .i_op (E_mdop),
    .i_a  (E_A),
    .i_b  (E_B),
    .o_hi (w_calc_hi),
    .o_lo (w_calc_lo)
  );

`ifdef MDU_DIVZERO_HOLD_EN
  assign w_skip = is_div(E_mdop) && (E_B == 32'd0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_launch = E_start && is_muldiv(E_mdop) && (r_state == StIdle);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_launch) begin
          w_state_d = StBusy;
          w_cnt_d   = is_div(E_mdop) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end
      end
      StBusy: begin
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == CntW'(1)) begin
          w_commit  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_temp_hi <= '0;
      r_temp_lo <= '0;
      r_skip    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_launch) begin
        r_temp_hi <= w_calc_hi;
        r_temp_lo <= w_calc_lo;
        r_skip    <= w_skip;
      end
      // Commit only happens while busy, and MT writes only while idle, so they never collide.
      if (w_commit && !r_skip) begin
        r_hi <= r_temp_hi;
        r_lo <= r_temp_lo;
      end else if (r_state == StIdle) begin
        if (E_mdop == MD_MTHI) r_hi <= E_A;
        if (E_mdop == MD_MTLO) r_lo <= E_A;
      end
    end
  end

  assign busy     = (r_state == StBusy);
  assign md_stall = D_is_md && (E_start || busy);

  always_comb begin
    E_mdout = '0;
    if (E_mdop == MD_MFHI) E_mdout = r_hi;
    if (E_mdop == MD_MFLO) E_mdout = r_lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a reference model predicts busy/md_stall/E_mdout per cycle,
// and a monitor compares them against the DUT at the falling edge.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, E_start, D_is_md;
  logic [3:0]  E_mdop;
  logic [31:0] E_A, E_B;
  logic        busy, md_stall;
  logic [31:0] E_mdout;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .E_start  (E_start),
    .E_mdop   (E_mdop),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_is_md  (D_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .E_mdout  (E_mdout)
  );

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] out;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Architectural model: committed HI/LO, pending result and cycles left until it lands.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pskip;
  int          m_left;

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV, MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit dmd);
    exp_t        e;
    logic [63:0] r;
    reset = rst; E_start = st; E_mdop = op; E_A = a; E_B = b; D_is_md = dmd;
    e.busy  = (m_left > 0);
    e.stall = dmd && (st || e.busy);
    e.out   = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
    e.cyc   = cyc;
    exp_q.push_back(e);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_pskip) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU)) begin
      r       = ref_calc(op, a, b);
      m_phi   = r[63:32];
      m_plo   = r[31:0];
      m_left  = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
`ifdef MDU_DIVZERO_HOLD_EN
      m_pskip = (op == MD_DIV || op == MD_DIVU) && (b == 0);
`else
      m_pskip = 0;
`endif
    end else begin
      if (op == MD_MTHI) m_hi = a;
      if (op == MD_MTLO) m_lo = a;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit dmd);
    for (int i = 0; i < n; i++) step(0, 0, MD_NONE, 32'd0, 32'd0, dmd);
  endtask

  task automatic read_hilo();
    step(0, 0, MD_MFHI, 32'd0, 32'd0, 0);
    step(0, 0, MD_MFLO, 32'd0, 32'd0, 0);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit dmd);
    step(0, 1, op, a, b, dmd);
    idle((op == MD_DIV || op == MD_DIVU) ? 11 : 6, dmd);
    read_hilo();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy cyc %0d got %b exp %b", e.cyc, busy, e.busy);
        end
        if (md_stall !== e.stall) begin
          errors++;
          $display("FAIL md_stall cyc %0d got %b exp %b", e.cyc, md_stall, e.stall);
        end
        if (E_mdout !== e.out) begin
          errors++;
          $display("FAIL E_mdout cyc %0d got %h exp %h", e.cyc, E_mdout, e.out);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1; E_start = 0; E_mdop = MD_NONE; E_A = 0; E_B = 0; D_is_md = 0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pskip = 0; m_left = 0;
    repeat (2) @(posedge clk);
    #1;
    read_hilo();
    run(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1);
    run(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
    run(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(MD_MULT, 32'd3, 32'd7, 0);
    step(0, 0, MD_MTHI, 32'h11, 32'd0, 0);
    step(0, 0, MD_MTLO, 32'h22, 32'd0, 0);
    run(MD_DIVU, 32'hDEAD_BEEF, 32'd0, 1);
    run(MD_DIV, 32'hCAFE_0001, 32'd0, 0);
    // Reset during busy cycle 3 of a DIV, then make sure nothing commits later.
    step(0, 0, MD_MTHI, 32'h99, 32'd0, 0);
    step(0, 1, MD_DIV, 32'd100, 32'd7, 1);
    idle(2, 1);
    step(1, 0, MD_NONE, 32'd0, 32'd0, 1);
    read_hilo();
    idle(12, 0);
    read_hilo();
    step(0, 0, MD_MTHI, 32'h1234, 32'd0, 0);
    step(0, 0, MD_MFHI, 32'd0, 32'd0, 0);
    // MTLO and a second start while busy must be ignored.
    step(0, 1, MD_MULT, 32'd6, 32'd7, 1);
    step(0, 0, MD_MTLO, 32'h55, 32'd0, 1);
    step(0, 1, MD_DIV, 32'd9, 32'd2, 1);
    idle(5, 1);
    read_hilo();
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 8));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 3);
        default: ;
      endcase
      step($urandom_range(0, 99) < 2, ($urandom_range(0, 2) == 0), op, a, b,
           $urandom_range(0, 1) == 1);
    end
    idle(12, 0);
    read_hilo();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
